// File: rtl/sub4_serial_pkg.sv
// Shared definitions for the bit-serial arithmetic units: FSM state encoding
// and the full-subtractor borrow equation.
package sub4_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Borrow out of a single full-subtractor stage computing a - b - bin.
    function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
        return (~a & b) | (~a & bin) | (b & bin);
    endfunction

endpackage

// File: rtl/sub4_serial_sub_cell.sv
// Combinational full-subtractor cell: d = a - b - bin (one bit), bout = borrow out.
module sub_cell
    import sub4_serial_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = fs_borrow(a, b, bin);

endmodule

// File: rtl/sub4_serial.sv
// Bit-serial subtractor computing a - b LSB first over WIDTH cycles with
// valid/ready handshakes. Optional signed-overflow output under SUB4_SERIAL_OVF_EN.
module sub4_serial
    import sub4_serial_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             out_valid,
    input  logic             out_ready
`ifdef SUB4_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic            bin;
    logic            d_bit;
    logic            bout_bit;
    logic            accept;
    logic            step;
    logic            last;

    sub_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (bin),
        .d    (d_bit),
        .bout (bout_bit)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && (state == IDLE);
    assign step      = (state == RUN);
    assign last      = step && (cnt == LAST);

    // Control: FSM state and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == LAST) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand shift registers and running borrow; no reset needed since
    // they are always reloaded on accept before being consumed.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= a;
            b_sh <= b;
            bin  <= 1'b0;
        end else if (step) begin
            a_sh <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
            bin  <= bout_bit;
        end
    end

    // Result: difference bits enter at the MSB so the word is LSB-aligned
    // after the final shift; diff is frozen once DONE is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff   <= '0;
            borrow <= 1'b0;
        end else if (step) begin
            diff <= {d_bit, diff[WIDTH-1:1]};
            if (last) begin
                borrow <= bout_bit;
            end
        end
    end

`ifdef SUB4_SERIAL_OVF_EN
    // On the last bit, a_sh[0]/b_sh[0] are the operand MSBs and d_bit is the result MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (last) begin
            ovf <= (a_sh[0] ^ b_sh[0]) & (d_bit ^ a_sh[0]);
        end
    end
`endif

endmodule

// File: tb/tb_sub4_serial.sv
// Directed self-checking bench for sub4_serial (WIDTH=4); build with or
// without SUB4_SERIAL_OVF_EN.
module tb_sub4_serial;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             out_valid;
    logic             out_ready;
`ifdef SUB4_SERIAL_OVF_EN
    logic             ovf;
`endif

    int total;
    int passed;

    sub4_serial #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .diff      (diff),
        .borrow    (borrow),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SUB4_SERIAL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Entered at a falling edge with the DUT idle; leaves at a falling edge.
    task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic [WIDTH-1:0] ed, input logic eb, input string tag);
        int lat;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        chk({tag, ".in_ready_idle"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".in_ready_run"}, {31'b0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat + 1), 32'(WIDTH + 1));
        chk({tag, ".diff"}, {28'b0, diff}, {28'b0, ed});
        chk({tag, ".borrow"}, {31'b0, borrow}, {31'b0, eb});
`ifdef SUB4_SERIAL_OVF_EN
        chk({tag, ".ovf"}, {31'b0, ovf},
            {31'b0, (va[WIDTH-1] != vb[WIDTH-1]) && (ed[WIDTH-1] != va[WIDTH-1])});
`endif
        if (out_ready) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".in_ready_after"}, {31'b0, in_ready}, 32'd1);
            chk({tag, ".out_valid_after"}, {31'b0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        logic [11:0] acc_mask;
        int          nres;
        logic        stable;

        total     = 0;
        passed    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.diff", {28'b0, diff}, 32'd0);
        chk("rst.borrow", {31'b0, borrow}, 32'd0);
`ifdef SUB4_SERIAL_OVF_EN
        chk("rst.ovf", {31'b0, ovf}, 32'd0);
`endif

        run_op(4'b1011, 4'b1000, 4'b0011, 1'b0, "t1");
        run_op(4'b1000, 4'b1011, 4'b1101, 1'b1, "t2");
        run_op(4'b0111, 4'b1000, 4'b1111, 1'b1, "t3");

        // Abort mid-RUN; diff/borrow currently hold 1111/1 from t3.
        a        = 4'b1111;
        b        = 4'b0001;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort.out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort.diff", {28'b0, diff}, 32'd0);
        chk("abort.borrow", {31'b0, borrow}, 32'd0);
        chk("abort.in_ready", {31'b0, in_ready}, 32'd1);
        repeat (6) @(negedge clk);
        chk("abort.quiet", {31'b0, out_valid}, 32'd0);
        run_op(4'b0110, 4'b0001, 4'b0101, 1'b0, "post_rst");

        // in_valid held high: accepts only at cycles 0 and 6 of the window.
        acc_mask = '0;
        nres     = 0;
        a        = 4'b0000;
        b        = 4'b0000;
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            acc_mask[i] = in_ready;
            if (out_valid) begin
                nres++;
                chk("hold.diff", {28'b0, diff}, 32'd0);
                chk("hold.borrow", {31'b0, borrow}, 32'd0);
            end
            if (i == 1) begin
                a = 4'b1111;
                b = 4'b1111;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("hold.accepts", {20'b0, acc_mask}, 32'h041);
        chk("hold.results", 32'(nres), 32'd2);
        @(negedge clk);

        // Backpressure: result must hold for 10 stalled cycles.
        out_ready = 1'b0;
        run_op(4'b0101, 4'b0011, 4'b0010, 1'b0, "bp");
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(out_valid === 1'b1 && diff === 4'b0010 && borrow === 1'b0 && in_ready === 1'b0))
                stable = 1'b0;
        end
        chk("bp.stable", {31'b0, stable}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp.in_ready", {31'b0, in_ready}, 32'd1);
        chk("bp.out_valid", {31'b0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sub4_serial.md
# sub4_serial

Bit-serial ripple subtractor computing `a - b` one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It is the subtract-direction counterpart to the combinational ripple adder in the arithmetic library. It trades WIDTH cycles of latency for one cell of logic. Operands enter and the result leaves through valid/ready handshakes, so it drops into sequential datapaths.

## Interface
- `WIDTH`, default 4: operand and result width in bits, minimum 2.
- `clk`  in  1  system clock; one clock domain, all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  operands present on `a`/`b`.
- `in_ready`  out  1  block can accept operands.
- `a`  in  WIDTH  minuend, unsigned two's-complement bit pattern.
- `b`  in  WIDTH  subtrahend.
- `diff`  out  WIDTH  `a - b` mod 2^WIDTH; valid while `out_valid`.
- `borrow`  out  1  final borrow; 1 iff `a < b` unsigned.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `ovf`  out  1  signed overflow; present only with `SUB4_SERIAL_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`, latch `a` and `b` into shift registers, clear the borrow register and bit counter, then go to RUN.
- RUN:
  - Each cycle, take bit `i` of the latched `a` and `b` plus the borrow register.
  - Difference bit = `a_i ^ b_i ^ bin`.
  - Next borrow = `(~a_i & b_i) | (~a_i & bin) | (b_i & bin)`.
  - Shift the difference bit into the result register from the MSB end, so the result is LSB-aligned after WIDTH shifts. Increment the counter.
  - After the bit WIDTH-1 cycle, go to DONE with `borrow` = final borrow.
- DONE:
  - `out_valid`=1. `diff`, `borrow` and `ovf` hold stable until `out_valid & out_ready`, then return to IDLE.
- `in_ready`=0 in RUN and DONE. `in_valid` in those states is ignored and not queued.
- Counter width is `$clog2(WIDTH)` bits. It never wraps within an operation, because the transition to DONE occurs at count WIDTH-1.
- Reset in any state, including mid-RUN or in DONE: the operation is aborted and discarded and the FSM goes to IDLE.
- Reset values: `in_ready`=1 in the cycle after reset; `out_valid`=0; `diff`=0; `borrow`=0; `ovf`=0.

## Timing
- Accept edge at cycle T. RUN occupies cycles T+1 through T+WIDTH. `out_valid` rises at T+WIDTH+1.
- If `out_ready` is already 1, the result is consumed at T+WIDTH+1 and `in_ready` is 1 at T+WIDTH+2.
- Minimum initiation interval is WIDTH+2 cycles.
- All outputs are registered, with no combinational path from inputs to outputs. `in_ready` and `out_valid` decode from the state register only.
- `out_ready` held low stalls DONE indefinitely; outputs must not change while stalled.

## Configuration
- `SUB4_SERIAL_OVF_EN` defined:
  - Port `ovf` exists.
  - `ovf` = `(a[W-1] != b[W-1]) & (diff[W-1] != a[W-1])`, computed from the latched operand MSBs and the final difference MSB.
  - `ovf` is registered at entry to DONE and reset to 0.
- `SUB4_SERIAL_OVF_EN` undefined: the `ovf` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared arithmetic package holds:
  - FSM state enum (IDLE/RUN/DONE), 2-bit encoding.
  - Full-subtractor borrow function, so it is reusable by other serial units.
- One sub-module: `sub_cell`, the combinational full-subtractor with ports `a`, `b`, `bin`, `d`, `bout`. It is instantiated once in RUN's datapath.
- Top level contains the FSM, counter, operand/result shift registers and borrow flop.

## Test plan
- a=1011, b=1000, `out_ready`=1 → `out_valid` at accept+5 with diff=0011, borrow=0, ovf=0.
- a=1000, b=1011 → diff=1101, borrow=1, ovf=0.
- a=0111, b=1000 → diff=1111, borrow=1, ovf=1 (build with macro). The same stimulus without the macro has no `ovf` port and gives identical `diff`/`borrow`.
- a=0000, b=0000 and a=1111, b=1111 → diff=0000, borrow=0. With `in_valid` held high throughout, `in_ready` stays 0 in RUN/DONE and exactly one operation is accepted per 6 cycles.
- Backpressure:
  - a=0101, b=0011, `out_ready`=0 for 10 cycles → diff=0010 and `out_valid`=1 hold stable.
  - The consume edge then gives `in_ready`=1 on the next cycle.
- Assert `rst` in the 2nd RUN cycle → the next cycle shows `out_valid`=0, diff=0, borrow=0, `in_ready`=1. A new op a=0110, b=0001 then yields diff=0101.
